// File: rtl/reflex_judge.sv
// reflex_judge: per-round hit/wrong/timeout judge with score, saturating wrong count and game_over.
// Define EARLY_PRESS_PENALTY_EN to count key rises while ARMED (no target yet) as wrong events.
module reflex_judge #(
  parameter int WINDOW_MS   = 500,
  parameter int COOLDOWN_MS = 100,
  parameter int MAX_WRONG   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       target_valid,
  input  logic [2:0] target_lane,
  output logic       target_ready,
  input  logic [7:0] key,
  output logic       hit_pulse,
  output logic       wrong_pulse,
  output logic [7:0] wrong_code,
  output logic [9:0] reaction_ms,
  output logic [7:0] score,
  output logic [2:0] wrong_cnt,
  output logic       game_over,
  output logic       busy
);
`ifdef EARLY_PRESS_PENALTY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam logic [2:0] MAXW = 3'(MAX_WRONG);
  localparam logic [9:0] WIN_LAST = 10'(WINDOW_MS - 1);
  localparam logic [9:0] CD = 10'(COOLDOWN_MS);
  typedef enum logic [1:0] {IDLE, ARMED, WINDOW, COOLDOWN} state_t;
  state_t state_q, state_d;
  logic [7:0] key_q, rise, tgt_q, tgt_d, score_q, score_d, wrong_code_q, wrong_code_d;
  logic [9:0] timer_q, timer_d, reaction_q, reaction_d;
  logic [2:0] wrong_cnt_q, wrong_cnt_d, wrong_sat;
  logic hit_q, hit_d, wrong_q, wrong_d;
  assign rise = key & ~key_q;
  assign wrong_sat = (wrong_cnt_q == MAXW) ? wrong_cnt_q : wrong_cnt_q + 3'd1;
  assign game_over = wrong_cnt_q == MAXW;
  assign target_ready = (state_q == ARMED) && !game_over;
  assign busy = (state_q == WINDOW) || (state_q == COOLDOWN);
  assign hit_pulse = hit_q;
  assign wrong_pulse = wrong_q;
  assign wrong_code = wrong_code_q;
  assign reaction_ms = reaction_q;
  assign score = score_q;
  assign wrong_cnt = wrong_cnt_q;
  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    timer_d = timer_q;
    score_d = score_q;
    wrong_code_d = wrong_code_q;
    reaction_d = reaction_q;
    wrong_cnt_d = wrong_cnt_q;
    hit_d = 1'b0;
    wrong_d = 1'b0;
    if (start) begin
      score_d = '0;
      wrong_cnt_d = '0;
      reaction_d = '0;
      wrong_code_d = '0;
      state_d = ARMED;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        ARMED: begin
          if (EARLY && rise != 8'd0) begin
            wrong_d = 1'b1;
            wrong_code_d = rise;
            wrong_cnt_d = wrong_sat;
          end
          if (target_valid && target_ready) begin
            tgt_d = 8'd1 << target_lane;
            timer_d = '0;
            state_d = WINDOW;
          end
        end
        WINDOW: begin
          // key events take priority over a timeout landing on the same clk
          if (rise == tgt_q) begin
            hit_d = 1'b1;
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            reaction_d = timer_q;
          end else if (rise != 8'd0 || (tick && timer_q == WIN_LAST)) begin
            wrong_d = 1'b1;
            wrong_code_d = rise;
            wrong_cnt_d = wrong_sat;
          end else if (tick) begin
            timer_d = timer_q + 10'd1;
          end
          if (hit_d || wrong_d) begin
            timer_d = '0;
            state_d = COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (timer_q >= CD && key == 8'd0) state_d = game_over ? IDLE : ARMED;
          else if (tick && timer_q < CD) timer_d = timer_q + 10'd1;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q <= '0;
      tgt_q <= '0;
      timer_q <= '0;
      score_q <= '0;
      wrong_code_q <= '0;
      reaction_q <= '0;
      wrong_cnt_q <= '0;
      hit_q <= 1'b0;
      wrong_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q <= key;
      tgt_q <= tgt_d;
      timer_q <= timer_d;
      score_q <= score_d;
      wrong_code_q <= wrong_code_d;
      reaction_q <= reaction_d;
      wrong_cnt_q <= wrong_cnt_d;
      hit_q <= hit_d;
      wrong_q <= wrong_d;
    end
  end
endmodule

// File: tb/tb_reflex_judge.sv
// tb_reflex_judge: directed rounds checked every cycle against a tick-count based model plus literal spot checks.
module tb_reflex_judge;
  localparam int WIN = 500;
  localparam int CD = 100;
  localparam int MAXW = 7;
`ifdef EARLY_PRESS_PENALTY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 0, rst_n = 0, tick = 0, start = 0, target_valid = 0;
  logic [2:0] target_lane = 0;
  logic [7:0] key = 0;
  logic target_ready, hit_pulse, wrong_pulse, game_over, busy;
  logic [7:0] wrong_code, score;
  logic [9:0] reaction_ms;
  logic [2:0] wrong_cnt;
  logic [33:0] dv;
  int compared = 0, mism = 0;
  bit chk = 0;
  reflex_judge dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
    .target_valid(target_valid), .target_lane(target_lane), .target_ready(target_ready),
    .key(key), .hit_pulse(hit_pulse), .wrong_pulse(wrong_pulse), .wrong_code(wrong_code),
    .reaction_ms(reaction_ms), .score(score), .wrong_cnt(wrong_cnt),
    .game_over(game_over), .busy(busy)
  );
  always #5 clk = ~clk;
  assign dv = {target_ready, hit_pulse, wrong_pulse, wrong_code, reaction_ms, score, wrong_cnt, game_over, busy};
  // model: phases plus a free-running tick count; elapsed time is a difference of tick counts
  int m_mode = 0, m_score = 0, m_wrong = 0, m_react = 0, m_ticks = 0, m_mark = 0;
  logic [7:0] m_prev = 0, m_tgt = 0, m_code = 0;
  bit m_hit = 0, m_wp = 0;
  always @(posedge clk) begin
    logic [7:0] rise;
    int el;
    bit rdy;
    rise = key & ~m_prev;
    el = m_ticks - m_mark;
    rdy = (m_mode == 1) && (m_wrong != MAXW);
    m_hit = 0;
    m_wp = 0;
    if (!rst_n) begin
      m_mode = 0; m_score = 0; m_wrong = 0; m_react = 0; m_code = 0; m_tgt = 0; m_prev = 0;
    end else begin
      if (start) begin
        m_score = 0; m_wrong = 0; m_react = 0; m_code = 0; m_mode = 1;
      end else if (m_mode == 1) begin
        if (EARLY && rise != 0) begin
          m_wp = 1; m_code = rise; if (m_wrong < MAXW) m_wrong++;
        end
        if (target_valid && rdy) begin
          m_tgt = 8'd1 << target_lane; m_mark = m_ticks + int'(tick); m_mode = 2;
        end
      end else if (m_mode == 2) begin
        if (rise == m_tgt) begin
          m_hit = 1; if (m_score < 255) m_score++; m_react = el;
        end else if (rise != 0 || (tick && el == WIN - 1)) begin
          m_wp = 1; m_code = rise; if (m_wrong < MAXW) m_wrong++;
        end
        if (m_hit || m_wp) begin
          m_mark = m_ticks + int'(tick); m_mode = 3;
        end
      end else if (m_mode == 3 && el >= CD && key == 0) begin
        m_mode = (m_wrong == MAXW) ? 0 : 1;
      end
      m_prev = key;
    end
    m_ticks += int'(tick);
  end
  always @(negedge clk) if (chk) begin
    logic [33:0] ev;
    ev = {m_mode == 1 && m_wrong != MAXW, m_hit, m_wp, m_code, 10'(m_react), 8'(m_score),
          3'(m_wrong), m_wrong == MAXW, m_mode >= 2};
    compared++;
    if (dv !== ev) begin
      mism++;
      $display("FAIL cycle_model @%0t: got %h expected %h", $time, dv, ev);
    end
  end
  task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic ticks(input int n);
    tick = 1;
    repeat (n) @(negedge clk);
    tick = 0;
  endtask
  task automatic offer(input int l);
    target_valid = 1;
    target_lane = 3'(l);
    step();
    target_valid = 0;
  endtask
  task automatic cool();
    ticks(CD);
    step();
    step();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    step(); step();
    chk = 1;
    lit("reset_outputs", 64'(dv), 0);
    rst_n = 1;
    step();
    start = 1; step(); start = 0;
    lit("armed_ready", 64'(target_ready), 1);
    offer(3);
    lit("window_busy", 64'(busy), 1);
    ticks(120);
    key = 8'h08; step();
    lit("t1_hit", 64'(hit_pulse), 1);
    lit("t1_score", 64'(score), 1);
    lit("t1_reaction", 64'(reaction_ms), 120);
    lit("t1_no_wrong", 64'(wrong_pulse), 0);
    key = 0; cool();
    lit("t1_rearmed", 64'(target_ready), 1);
    offer(2);
    key = 8'h41; step();
    lit("t2_wrong", 64'(wrong_pulse), 1);
    lit("t2_code", 64'(wrong_code), 8'h41);
    lit("t2_cnt", 64'(wrong_cnt), 1);
    ticks(110);
    lit("t2_held_busy", 64'(busy), 1);
    lit("t2_held_ready", 64'(target_ready), 0);
    key = 0; step(); step();
    lit("t2_released", 64'(target_ready), 1);
    offer(2);
    key = 8'h05; step();
    lit("multi_code", 64'(wrong_code), 8'h05);
    lit("multi_cnt", 64'(wrong_cnt), 2);
    key = 0; cool();
    offer(0);
    ticks(499);
    lit("t3_before_timeout", 64'(wrong_pulse), 0);
    ticks(1);
    lit("t3_timeout", 64'(wrong_pulse), 1);
    lit("t3_code", 64'(wrong_code), 0);
    lit("t3_cnt", 64'(wrong_cnt), 3);
    cool();
    offer(0);
    ticks(499);
    tick = 1; key = 8'h01; step(); tick = 0;
    lit("t3_tie_hit", 64'(hit_pulse), 1);
    lit("t3_tie_no_wrong", 64'(wrong_pulse), 0);
    lit("t3_tie_reaction", 64'(reaction_ms), 499);
    lit("t3_tie_score", 64'(score), 2);
    key = 0; cool();
    start = 1; step(); start = 0;
    lit("start_clears", 64'({score, wrong_cnt, reaction_ms, wrong_code}), 0);
    for (int i = 0; i < 7; i++) begin
      offer(i);
      ticks(WIN);
      cool();
    end
    lit("t4_cnt", 64'(wrong_cnt), 7);
    lit("t4_game_over", 64'(game_over), 1);
    lit("t4_ready", 64'(target_ready), 0);
    target_valid = 1; target_lane = 1; repeat (3) step(); target_valid = 0;
    lit("t4_valid_ignored", 64'(busy), 0);
    start = 1; step(); start = 0;
    lit("t4_restart", 64'({wrong_cnt, game_over, target_ready}), 1);
    offer(5);
    ticks(10);
    key = 8'h20; rst_n = 0; step();
    lit("t5_reset", 64'(dv), 0);
    rst_n = 1; step();
    start = 1; step(); start = 0;
    offer(5);
    ticks(3);
    lit("t5_held_no_hit", 64'({hit_pulse, score, busy}), 1);
    key = 0; step();
    key = 8'h20; step();
    lit("t5_fresh_hit", 64'({hit_pulse, score}), 9'h101);
    key = 0; cool();
    key = 8'h10; step();
    lit("t6_wrong", 64'(wrong_pulse), 64'(EARLY));
    lit("t6_code", 64'(wrong_code), EARLY ? 8'h10 : 8'h00);
    lit("t6_cnt", 64'(wrong_cnt), EARLY ? 1 : 0);
    lit("t6_still_armed", 64'({target_ready, busy}), 2'b10);
    key = 0; step();
    target_valid = 1; target_lane = 4; key = 8'h80; step(); target_valid = 0; key = 0;
    lit("t6_accept_busy", 64'(busy), 1);
    lit("t6_accept_wrong", 64'(wrong_pulse), 64'(EARLY));
    key = 8'h10; step();
    lit("t6_then_hit", 64'(hit_pulse), 1);
    key = 0; cool();
    offer(6);
    key = 8'h40; start = 1; step(); start = 0; key = 0;
    lit("start_overrides", 64'({hit_pulse, wrong_pulse, target_ready, busy, score}), 64'h200);
    for (int i = 0; i < 256; i++) begin
      offer(i % 8);
      key = 8'(1 << (i % 8)); step();
      key = 0; cool();
    end
    lit("score_saturates", 64'(score), 255);
    chk = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
